// File: rtl/vec_stream_finder_if.sv
// Stream, control and result bundle between a stream-side master and vec_stream_finder.
// io_last_index exists only when VEC_FINDER_LAST_MATCH_EN is defined.
interface vec_stream_finder_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 3
);
    logic [WIDTH-1:0] io_in;
    logic             io_in_valid;
    logic             io_start;
    logic [WIDTH-1:0] io_target;
    logic [IDX_W-1:0] io_len;
    logic             io_busy;
    logic             io_done;
    logic             io_found;
    logic [IDX_W-1:0] io_index;
    logic [IDX_W-1:0] io_count;
`ifdef VEC_FINDER_LAST_MATCH_EN
    logic [IDX_W-1:0] io_last_index;
`endif

    modport master (
        output io_in, io_in_valid, io_start, io_target, io_len,
        input  io_busy, io_done, io_found, io_index, io_count
`ifdef VEC_FINDER_LAST_MATCH_EN
        , input io_last_index
`endif
    );

    modport slave (
        input  io_in, io_in_valid, io_start, io_target, io_len,
        output io_busy, io_done, io_found, io_index, io_count
`ifdef VEC_FINDER_LAST_MATCH_EN
        , output io_last_index
`endif
    );
endinterface

// File: rtl/vec_stream_finder.sv
// Scans a window of the VecSearch element stream for a target; reports found/first index/count.
// Define VEC_FINDER_LAST_MATCH_EN to add io_last_index (index of the most recent match).
module vec_stream_finder #(
    parameter int WIDTH   = 4,
    parameter int MAX_LEN = 7,
    parameter int IDX_W   = 3
) (
    input  logic                clock,
    input  logic                reset,
    vec_stream_finder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] ZERO_C    = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_C     = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] CNT_MAX_C = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] MAX_LEN_C = IDX_W'(MAX_LEN);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] target_q,   target_d;
    logic [IDX_W-1:0] len_q,      len_d;
    logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
    logic             found_q,    found_d;
    logic [IDX_W-1:0] index_q,    index_d;
    logic [IDX_W-1:0] count_q,    count_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
`ifdef VEC_FINDER_LAST_MATCH_EN
    logic [IDX_W-1:0] last_q,     last_d;
`endif
    logic [IDX_W-1:0] len_clamp_s;
    logic             match_s;

    // Clamp the requested window to the table depth before it is latched.
    always_comb begin
        if (bus.io_len > MAX_LEN_C) begin
            len_clamp_s = MAX_LEN_C;
        end else begin
            len_clamp_s = bus.io_len;
        end
    end

    // Element compare against the latched target.
    always_comb begin
        match_s = (bus.io_in == target_q);
    end

    // Next-state and datapath updates for IDLE / SEARCH / DONE.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        len_d      = len_q;
        elem_idx_d = elem_idx_q;
        found_d    = found_q;
        index_d    = index_q;
        count_d    = count_q;
`ifdef VEC_FINDER_LAST_MATCH_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.io_start) begin
                    target_d   = bus.io_target;
                    len_d      = len_clamp_s;
                    elem_idx_d = ZERO_C;
                    found_d    = 1'b0;
                    index_d    = ZERO_C;
                    count_d    = ZERO_C;
`ifdef VEC_FINDER_LAST_MATCH_EN
                    last_d     = ZERO_C;
`endif
                    if (len_clamp_s == ZERO_C) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                // A cycle without io_in_valid is a stall: nothing moves.
                if (bus.io_in_valid) begin
                    if (match_s) begin
                        if (count_q != CNT_MAX_C) begin
                            count_d = count_q + ONE_C;
                        end else begin
                            count_d = count_q;
                        end
                        if (!found_q) begin
                            found_d = 1'b1;
                            index_d = elem_idx_q;
                        end else begin
                            found_d = found_q;
                        end
`ifdef VEC_FINDER_LAST_MATCH_EN
                        last_d = elem_idx_q;
`endif
                    end else begin
                        count_d = count_q;
                    end
                    elem_idx_d = elem_idx_q + ONE_C;
                    if (elem_idx_q == (len_q - ONE_C)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags are decoded from the next state so they leave a flop.
        busy_d = (state_d == ST_SEARCH);
        done_d = (state_d == ST_DONE);
    end

    // State and result registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            target_q   <= {WIDTH{1'b0}};
            len_q      <= ZERO_C;
            elem_idx_q <= ZERO_C;
            found_q    <= 1'b0;
            index_q    <= ZERO_C;
            count_q    <= ZERO_C;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef VEC_FINDER_LAST_MATCH_EN
            last_q     <= ZERO_C;
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            len_q      <= len_d;
            elem_idx_q <= elem_idx_d;
            found_q    <= found_d;
            index_q    <= index_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef VEC_FINDER_LAST_MATCH_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.io_busy  = busy_q;
    assign bus.io_done  = done_q;
    assign bus.io_found = found_q;
    assign bus.io_index = index_q;
    assign bus.io_count = count_q;
`ifdef VEC_FINDER_LAST_MATCH_EN
    assign bus.io_last_index = last_q;
`endif

endmodule
